pc_fetch_unit: RTL

- Fetch-stage program counter and instruction-memory requester, directly upstream of the decode stage.
- Holds the word-granular PC and drives the instruction-memory byte address as PC shifted left by two.
- Issues one request at a time to a variable-latency instruction memory and presents each returned instruction to decode through a one-entry valid/ready buffer.
- Accepts redirects (branch/jump/exception target, word address) at any time and squashes any in-flight or buffered fetch.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 31 +++
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and address widths.
package fetch_pkg;

    localparam int unsigned WORD_AW = 32;
    localparam int unsigned BYTE_AW = 32;
    localparam int unsigned INSTR_W = 32;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_REQ  = 2'd0;
    localparam fetch_state_t S_HOLD = 2'd1;
    localparam fetch_state_t S_DROP = 2'd2;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched instruction and its word-address PC.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [WORD_AW-1:0] pc_d,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [WORD_AW-1:0] pc
);

    // Data is left in place on clear; only valid drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_d;
            pc    <= pc_d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC and single-outstanding instruction-memory requester with a
// one-entry valid/ready buffer towards decode and squashing redirects.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [WORD_AW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [BYTE_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [WORD_AW-1:0] redirect_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [WORD_AW-1:0] if_pc
);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [WORD_AW-1:0] pc_q;
    logic [WORD_AW-1:0] pc_d;
    logic [WORD_AW-1:0] pend_q;
    logic               pc_load;
    logic               pend_load;
    logic               buf_load;
    logic               buf_clr;
    logic               buf_valid;

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_REQ;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) state_d = imem_ack ? S_REQ : S_DROP;
                else if (imem_ack)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (redirect_valid || if_ready) state_d = S_REQ;
            end
            S_DROP: begin
                if (imem_ack) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Datapath strobes; redirect always outranks ack/handshake.
    always_comb begin
        pc_load   = 1'b0;
        pc_d      = pc_q;
        pend_load = 1'b0;
        buf_load  = 1'b0;
        buf_clr   = 1'b0;
        imem_req  = 1'b0;
        if_valid  = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req = ~reset;
                if (redirect_valid) begin
                    if (imem_ack) begin
                        pc_load = 1'b1;
                        pc_d    = redirect_target;
                    end else begin
                        pend_load = 1'b1;
                    end
                end else if (imem_ack) begin
                    buf_load = 1'b1;
                    pc_load  = 1'b1;
                    pc_d     = pc_q + WORD_AW'(1);
                end
            end
            S_HOLD: begin
                if_valid = buf_valid & ~reset;
                if (redirect_valid) begin
                    buf_clr = 1'b1;
                    pc_load = 1'b1;
                    pc_d    = redirect_target;
                end else if (if_ready) begin
                    buf_clr = 1'b1;
                end
            end
            S_DROP: begin
                imem_req = ~reset;
                if (redirect_valid) begin
                    if (imem_ack) begin
                        pc_load = 1'b1;
                        pc_d    = redirect_target;
                    end else begin
                        pend_load = 1'b1;
                    end
                end else if (imem_ack) begin
                    pc_load = 1'b1;
                    pc_d    = pend_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
        end else begin
            if (pc_load)   pc_q   <= pc_d;
            if (pend_load) pend_q <= redirect_target;
        end
    end

    // Upper two PC bits fall off the byte address.
    assign imem_addr = {pc_q[WORD_AW-3:0], 2'b00};

    fetch_buffer u_buf (
        .clock   (clock),
        .reset   (reset),
        .load    (buf_load),
        .clear   (buf_clr),
        .instr_d (imem_rdata),
        .pc_d    (pc_q),
        .valid   (buf_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );

endmodule
